// File: rtl/reset_sequencer.sv
// Turns single-cycle short/long reset pulses into stretched, ordered resets
// for the config, link and datapath domains, with event counters and a lock-timeout flag.
module reset_sequencer #(
  parameter int SHORT_HOLD   = 16,
  parameter int LONG_HOLD    = 256,
  parameter int STAGE_GAP    = 8,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             short_reset,
  input  logic             long_reset,
  input  logic             pll_locked,
  input  logic             clr_counts,
  output logic             config_rst,
  output logic             link_rst,
  output logic             datapath_rst,
  output logic             busy,
  output logic             lock_err,
  output logic [CNT_W-1:0] short_count,
  output logic [CNT_W-1:0] long_count
);

  localparam int MAX_A    = (LONG_HOLD > LOCK_TIMEOUT) ? LONG_HOLD : LOCK_TIMEOUT;
  localparam int MAX_B    = (SHORT_HOLD > STAGE_GAP) ? SHORT_HOLD : STAGE_GAP;
  localparam int MAX_LOAD = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW       = (MAX_LOAD > 1) ? $clog2(MAX_LOAD) : 1;

  localparam logic [TW-1:0] SHORT_LOAD = TW'(SHORT_HOLD - 1);
  localparam logic [TW-1:0] LONG_LOAD  = TW'(LONG_HOLD - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(STAGE_GAP - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [5:0] {
    S_IDLE     = 6'b000001,
    S_SHOLD    = 6'b000010,
    S_LHOLD    = 6'b000100,
    S_LOCKWAIT = 6'b001000,
    S_RELLINK  = 6'b010000,
    S_RELDP    = 6'b100000
  } state_t;

  state_t        state;
  logic [TW-1:0] cnt;
  logic          cnt_zero;
  logic          lock_timeout;
  logic          short_acc;

  assign cnt_zero     = (cnt == '0);
  assign short_acc    = short_reset & ~long_reset;
  assign lock_timeout = ~rst & ~long_reset & (state == S_LOCKWAIT) & ~pll_locked & cnt_zero;

  // Output pattern {config_rst, link_rst, datapath_rst, busy} while in a state.
  function automatic logic [3:0] outs_for(input state_t s);
    logic [3:0] o;
    o = 4'b1111;
    case (s)
      S_IDLE:     o = 4'b0000;
      S_SHOLD:    o = 4'b0011;
      S_LHOLD:    o = 4'b1111;
      S_LOCKWAIT: o = 4'b0111;
      S_RELLINK:  o = 4'b0111;
      S_RELDP:    o = 4'b0011;
      default:    o = 4'b1111;
    endcase
    return o;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || long_reset) begin
      state <= S_LHOLD;
      cnt   <= LONG_LOAD;
      {config_rst, link_rst, datapath_rst, busy} <= outs_for(S_LHOLD);
    end else begin
      case (state)
        S_IDLE: begin
          if (short_reset) begin
            state <= S_SHOLD;
            cnt   <= SHORT_LOAD;
            {config_rst, link_rst, datapath_rst, busy} <= outs_for(S_SHOLD);
          end
        end
        S_SHOLD: begin
          if (short_reset) begin
            cnt <= SHORT_LOAD;
          end else if (cnt_zero) begin
            state <= S_IDLE;
            {config_rst, link_rst, datapath_rst, busy} <= outs_for(S_IDLE);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LHOLD: begin
          if (cnt_zero) begin
            state <= S_LOCKWAIT;
            cnt   <= LOCK_LOAD;
            {config_rst, link_rst, datapath_rst, busy} <= outs_for(S_LOCKWAIT);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LOCKWAIT: begin
          // A timeout proceeds exactly as a lock would; lock_err records it.
          if (pll_locked || cnt_zero) begin
            state <= S_RELLINK;
            cnt   <= GAP_LOAD;
            {config_rst, link_rst, datapath_rst, busy} <= outs_for(S_RELLINK);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RELLINK: begin
          if (cnt_zero) begin
            state <= S_RELDP;
            cnt   <= GAP_LOAD;
            {config_rst, link_rst, datapath_rst, busy} <= outs_for(S_RELDP);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RELDP: begin
          if (cnt_zero) begin
            state <= S_IDLE;
            {config_rst, link_rst, datapath_rst, busy} <= outs_for(S_IDLE);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_LHOLD;
          cnt   <= LONG_LOAD;
          {config_rst, link_rst, datapath_rst, busy} <= outs_for(S_LHOLD);
        end
      endcase
    end
  end

  // Counters saturate; an event coinciding with a clear leaves the count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      short_count <= '0;
      long_count  <= '0;
      lock_err    <= 1'b0;
    end else begin
      if (clr_counts) begin
        short_count <= short_acc ? CNT_W'(1) : '0;
        long_count  <= long_reset ? CNT_W'(1) : '0;
      end else begin
        if (short_acc && (short_count != '1)) short_count <= short_count + 1'b1;
        if (long_reset && (long_count != '1)) long_count <= long_count + 1'b1;
      end
      if (lock_timeout) lock_err <= 1'b1;
      else if (clr_counts) lock_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench for reset_sequencer: tasks push timed expectations into a
// scoreboard queue which a negedge monitor pops and compares against the DUT.
module tb_reset_sequencer;
  localparam int SH  = 4;
  localparam int LH  = 8;
  localparam int GAP = 2;
  localparam int LT  = 20;

  logic       clk, rst, short_reset, long_reset, pll_locked, clr_counts;
  logic       config_rst, link_rst, datapath_rst, busy, lock_err;
  logic [7:0] short_count, long_count;

  reset_sequencer #(.SHORT_HOLD(SH), .LONG_HOLD(LH), .STAGE_GAP(GAP),
                    .LOCK_TIMEOUT(LT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .short_reset(short_reset), .long_reset(long_reset),
    .pll_locked(pll_locked), .clr_counts(clr_counts), .config_rst(config_rst),
    .link_rst(link_rst), .datapath_rst(datapath_rst), .busy(busy),
    .lock_err(lock_err), .short_count(short_count), .long_count(long_count));

  typedef struct {
    int         at;
    logic [3:0] rs;
    bit         chk_cnt;
    logic [7:0] sc;
    logic [7:0] lc;
    logic       le;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_sc = 0;
  logic [7:0] exp_lc = 0;
  logic       exp_le = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.at != cyc) begin
        n_bad++;
        $display("FAIL sb_stale: entry for cycle %0d seen at cycle %0d", e.at, cyc);
      end else begin
        if ({config_rst, link_rst, datapath_rst, busy} !== e.rs) begin
          n_bad++;
          $display("FAIL resets@%0d: got cfg/link/dp/busy=%b, want %b", cyc,
                   {config_rst, link_rst, datapath_rst, busy}, e.rs);
        end
        n_cmp++;
        if (lock_err !== e.le) begin
          n_bad++;
          $display("FAIL lock_err@%0d: got %b, want %b", cyc, lock_err, e.le);
        end
        if (e.chk_cnt) begin
          n_cmp++;
          if (short_count !== e.sc || long_count !== e.lc) begin
            n_bad++;
            $display("FAIL counts@%0d: got short=%0d long=%0d, want short=%0d long=%0d",
                     cyc, short_count, long_count, e.sc, e.lc);
          end
        end
      end
    end
  end

  // Expected trajectory of a long sequence: pulse sampled at t, lock sampled at u.
  task automatic push_long(input int t, input int u, input int le_from);
    for (int c = t + 1; c <= u + 1 + 2 * GAP; c++) begin
      if (c > cyc)
        sb.push_back('{c, {1'(c <= t + LH), 1'(c <= u + GAP), 1'(c <= u + 2 * GAP),
                           1'(c <= u + 2 * GAP)},
                       c == u + 1 + 2 * GAP, exp_sc, exp_lc,
                       (le_from >= 0 && c >= le_from) ? 1'b1 : exp_le});
    end
  endtask

  task automatic test_reset();
    int c;
    rst = 1; short_reset = 0; long_reset = 0; pll_locked = 1; clr_counts = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({config_rst, link_rst, datapath_rst, busy} !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_outs: got %b, want 1111", {config_rst, link_rst, datapath_rst, busy});
    end
    n_cmp++;
    if (short_count !== 0 || long_count !== 0 || lock_err !== 0) begin
      n_bad++;
      $display("FAIL reset_status: got sc=%0d lc=%0d le=%b, want 0 0 0",
               short_count, long_count, lock_err);
    end
    c = cyc;
    rst = 0;
    push_long(c - 1, c + 8, -1);
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain_reset: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_short();
    int t;
    @(negedge clk);
    t = cyc; short_reset = 1; exp_sc++;
    for (int c = t + 1; c <= t + SH + 1; c++)
      sb.push_back('{c, (c <= t + SH) ? 4'b0011 : 4'b0000, c == t + SH + 1, exp_sc, exp_lc, exp_le});
    @(negedge clk); short_reset = 0;
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain_short: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_late_lock();
    int t;
    pll_locked = 0;
    @(negedge clk);
    t = cyc; long_reset = 1; exp_lc++;
    push_long(t, t + 15, -1);
    @(negedge clk); long_reset = 0;
    for (int i = 0; i < 100 && sb.size() > 0; i++) begin
      if (cyc == t + 15) pll_locked = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain_late: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_timeout();
    int t, k;
    pll_locked = 0;
    @(negedge clk);
    t = cyc; long_reset = 1; exp_lc++;
    push_long(t, t + 8 + LT, t + 9 + LT);
    exp_le = 1;
    @(negedge clk); long_reset = 0;
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain_timeout: %0d left, want 0", sb.size()); end
    k = cyc; clr_counts = 1;
    exp_sc = 0; exp_lc = 0; exp_le = 0;
    sb.push_back('{k + 1, 4'b0000, 1'b1, exp_sc, exp_lc, exp_le});
    @(negedge clk); clr_counts = 0;
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain_clear: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_preempt();
    int t;
    pll_locked = 1;
    @(negedge clk);
    t = cyc; short_reset = 1; exp_sc++;
    sb.push_back('{t + 1, 4'b0011, 1'b0, exp_sc, exp_lc, exp_le});
    sb.push_back('{t + 2, 4'b0011, 1'b0, exp_sc, exp_lc, exp_le});
    @(negedge clk); short_reset = 0;
    @(negedge clk); long_reset = 1; exp_lc++;
    push_long(t + 2, t + 11, -1);
    @(negedge clk); long_reset = 0;
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain_preempt: %0d left, want 0", sb.size()); end
    // short pulse landing in LOCKWAIT: counted, outputs untouched
    pll_locked = 0;
    @(negedge clk);
    t = cyc; long_reset = 1; exp_lc++; exp_sc++;
    push_long(t, t + 14, -1);
    @(negedge clk); long_reset = 0;
    for (int i = 0; i < 100 && sb.size() > 0; i++) begin
      short_reset = (cyc == t + 12);
      if (cyc == t + 14) pll_locked = 1;
      @(negedge clk);
    end
    short_reset = 0;
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain_lockwait: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_both(input string tag);
    int t;
    pll_locked = 1;
    @(negedge clk);
    t = cyc; long_reset = 1; short_reset = 1;
    if (exp_lc != 8'hFF) exp_lc++;
    push_long(t, t + 9, -1);
    @(negedge clk); long_reset = 0; short_reset = 0;
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain_%s: %0d left, want 0", tag, sb.size()); end
  endtask

  task automatic test_saturation();
    int t;
    @(negedge clk);
    clr_counts = 1; exp_sc = 0; exp_lc = 0; exp_le = 0;
    sb.push_back('{cyc + 1, 4'b0000, 1'b1, exp_sc, exp_lc, exp_le});
    @(negedge clk); clr_counts = 0;
    test_both("both_first");
    for (int p = 0; p < 300; p++) begin
      @(negedge clk);
      t = cyc; short_reset = 1;
      if (exp_sc != 8'hFF) exp_sc++;
      sb.push_back('{t + 1, 4'b0011, 1'b1, exp_sc, exp_lc, exp_le});
      @(negedge clk); short_reset = 0;
      repeat (8) @(negedge clk);
    end
    n_cmp++;
    if (short_count !== 8'd255) begin
      n_bad++;
      $display("FAIL short_sat: got %0d, want 255", short_count);
    end
    test_both("both_sat");
  endtask

  initial begin
    test_reset();
    test_short();
    test_late_lock();
    test_timeout();
    test_preempt();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end
endmodule
